// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 operations,
// FSM states and small operation-decode helpers.
package muldiv_ctrl_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MD_ST_IDLE     = 3'd0,
    MD_ST_MUL      = 3'd1,
    MD_ST_DIV_ITER = 3'd2,
    MD_ST_FIXUP    = 3'd3,
    MD_ST_DONE     = 3'd4
  } md_state_e;

  // funct3[2] selects divide, funct3[1] selects remainder, funct3[0] unsigned.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic op_div_signed(input logic [2:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide sequencer connection, plus FSM state for observation.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  // Handshake: start_i is taken only in IDLE without flush_i; later starts are
  // dropped, not queued. done_o pulses one cycle with result_o valid, and
  // result_o then holds until the next accepted start.
  logic               start_i;
  logic [2:0]         op_i;
  logic [MD_XLEN-1:0] rs1_val_i;
  logic [MD_XLEN-1:0] rs2_val_i;
  logic               flush_i;
  logic               busy_o;
  logic               stall_o;
  logic               done_o;
  logic [MD_XLEN-1:0] result_o;
  md_state_e          state;

  modport master (
    output start_i, op_i, rs1_val_i, rs2_val_i, flush_i,
    input  busy_o, stall_o, done_o, result_o, state
  );

  modport slave (
    input  start_i, op_i, rs1_val_i, rs2_val_i, flush_i,
    output busy_o, stall_o, done_o, result_o, state
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath: one quotient bit per step, MSB first, on unsigned magnitudes.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // quo_q starts as the dividend and shifts left; its MSB feeds the remainder.
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dsr_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(XLEN - 1);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], !diff[XLEN]};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: two-cycle multiply, 32-step restoring divide with sign fixup,
// special-case divides resolved in one cycle; stalls execute until the result is ready.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  muldiv_ctrl_if.slave md
);

  md_state_e         state_q, state_n;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic              accept, special, div_by_zero, overflow, signed_div;
  logic              div_load, div_step, div_last;
  logic [XLEN-1:0]   special_val, mag_a, mag_b, quotient, remainder;
  logic [XLEN-1:0]   mul_val, fix_val;
  logic              a_sign, b_sign;
  logic [2*XLEN-1:0] a_ext, b_ext, product;

  assign accept      = (state_q == MD_ST_IDLE) && md.start_i && !md.flush_i;
  assign signed_div  = op_div_signed(md.op_i);
  assign div_by_zero = (md.rs2_val_i == '0);
  assign overflow    = signed_div && (md.rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (md.rs2_val_i == '1);
  assign special     = op_is_div(md.op_i) && (div_by_zero || overflow);
  assign div_load    = accept && op_is_div(md.op_i) && !special;

  assign mag_a = (signed_div && md.rs1_val_i[XLEN-1]) ? -md.rs1_val_i : md.rs1_val_i;
  assign mag_b = (signed_div && md.rs2_val_i[XLEN-1]) ? -md.rs2_val_i : md.rs2_val_i;

  always_comb begin
    special_val = '0;
    if (div_by_zero) special_val = op_is_rem(md.op_i) ? md.rs1_val_i : '1;
    else             special_val = op_is_rem(md.op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // 33x33 signed product; the low 64 bits of a 64x64 product of the extended
  // operands are identical, so a plain multiply is enough.
  assign a_sign  = (op_q != MD_OP_MULHU) && a_q[XLEN-1];
  assign b_sign  = ((op_q == MD_OP_MUL) || (op_q == MD_OP_MULH)) && b_q[XLEN-1];
  assign a_ext   = {{XLEN{a_sign}}, a_q};
  assign b_ext   = {{XLEN{b_sign}}, b_q};
  assign product = a_ext * b_ext;
  assign mul_val = (op_q == MD_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = quotient;
    if (op_is_rem(op_q))
      fix_val = (op_div_signed(op_q) && a_q[XLEN-1]) ? -remainder : remainder;
    else if (op_div_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]))
      fix_val = -quotient;
  end

  always_comb begin
    state_n  = state_q;
    div_step = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        if (accept) begin
          if (!op_is_div(md.op_i)) state_n = MD_ST_MUL;
          else if (special)        state_n = MD_ST_DONE;
          else                     state_n = MD_ST_DIV_ITER;
        end
      end
      MD_ST_MUL:   state_n = md.flush_i ? MD_ST_IDLE : MD_ST_DONE;
      MD_ST_DIV_ITER: begin
        if (md.flush_i) begin
          state_n = MD_ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) state_n = MD_ST_FIXUP;
        end
      end
      MD_ST_FIXUP: state_n = md.flush_i ? MD_ST_IDLE : MD_ST_DONE;
      MD_ST_DONE:  state_n = MD_ST_IDLE;
      default:     state_n = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MD_ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        op_q <= md.op_i;
        a_q  <= md.rs1_val_i;
        b_q  <= md.rs2_val_i;
      end
      if (accept && special)
        result_q <= special_val;
      else if ((state_q == MD_ST_MUL) && !md.flush_i)
        result_q <= mul_val;
      else if ((state_q == MD_ST_FIXUP) && !md.flush_i)
        result_q <= fix_val;
    end
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (div_last)
  );

  assign md.busy_o   = (state_q != MD_ST_IDLE);
  assign md.stall_o  = ((state_q == MD_ST_IDLE) && md.start_i)
                       || ((state_q != MD_ST_IDLE) && (state_q != MD_ST_DONE));
  assign md.done_o   = (state_q == MD_ST_DONE);
  assign md.result_o = result_q;
  assign md.state    = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random M-extension operations against an
// arithmetic reference model, plus ignored-start, flush and async-reset scenarios.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .md    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: plain 64-bit and integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // driver: call away from the rising edge; returns at the negedge after DONE
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int exp_lat;
    int seen;
    logic [31:0] exp_res;
    exp_q.push_back(ref_result(op, a, b));
    exp_lat = ref_latency(op, a, b);
    bus.op_i      = op;
    bus.rs1_val_i = a;
    bus.rs2_val_i = b;
    bus.start_i   = 1'b1;
    #1;
    chk({tag, " stall/busy c0"}, 32'({bus.stall_o, bus.busy_o}), 32'b10);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    seen = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = c;
        break;
      end
      chk({tag, " stall/busy wait"}, 32'({bus.stall_o, bus.busy_o}), 32'b11);
    end
    chk({tag, " latency"}, 32'(seen), 32'(exp_lat));
    exp_res = exp_q.pop_front();
    chk({tag, " result"}, bus.result_o, exp_res);
    chk({tag, " stall/busy done"}, 32'({bus.stall_o, bus.busy_o}), 32'b01);
    @(negedge clk);
    chk({tag, " done/busy after"}, 32'({bus.done_o, bus.busy_o}), 32'b00);
    chk({tag, " result held"}, bus.result_o, exp_res);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          cnt, seen;
    logic [31:0] res;

    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.op_i      = '0;
    bus.rs1_val_i = '0;
    bus.rs2_val_i = '0;
    #2;
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset done", 32'(bus.done_o), 32'd0);
    chk("reset result", bus.result_o, 32'd0);
    chk("reset stall", 32'(bus.stall_o), 32'd0);
    chk("reset state", 32'(bus.state), 32'(MD_ST_IDLE));
    bus.start_i = 1'b1;
    #1 chk("reset stall with start", 32'(bus.stall_o), 32'd1);
    bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed operations
    run_op("mul", MD_OP_MUL, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh", MD_OP_MULH, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", MD_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem", MD_OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", MD_OP_DIVU, 32'd100, 32'd7);
    run_op("remu", MD_OP_REMU, 32'd100, 32'd7);
    run_op("div0", MD_OP_DIV, 32'd5, 32'd0);
    run_op("rem0", MD_OP_REM, 32'd5, 32'd0);
    run_op("div ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf", MD_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);

    // random operations with biased special-case operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("random", rop, ra, rb);
    end

    // a second start while busy is dropped
    bus.op_i = MD_OP_DIVU; bus.rs1_val_i = 32'd100; bus.rs2_val_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    cnt = 0; seen = -1; res = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.op_i = MD_OP_MUL; bus.rs1_val_i = 32'd3; bus.rs2_val_i = 32'd4;
        bus.start_i = 1'b1;
      end else if (c == 6) begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o) begin
        cnt++;
        if (seen < 0) begin
          seen = c;
          res  = bus.result_o;
        end
      end
    end
    chk("busy start done count", 32'(cnt), 32'd1);
    chk("busy start latency", 32'(seen), 32'd34);
    chk("busy start result", res, 32'd14);

    // flush mid-divide
    run_op("pre-flush mul", MD_OP_MUL, 32'd5, 32'd5);
    bus.op_i = MD_OP_DIVU; bus.rs1_val_i = 32'd100; bus.rs2_val_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush state c11", 32'(bus.state), 32'(MD_ST_IDLE));
    chk("flush busy c11", 32'(bus.busy_o), 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o) cnt++;
    end
    chk("flush no done", 32'(cnt), 32'd0);
    chk("flush result kept", bus.result_o, 32'd25);
    run_op("post-flush divu", MD_OP_DIVU, 32'd9, 32'd2);

    // start together with flush in IDLE is refused
    bus.op_i = MD_OP_MUL; bus.rs1_val_i = 32'd2; bus.rs2_val_i = 32'd2;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    @(posedge clk);
    #1 begin bus.start_i = 1'b0; bus.flush_i = 1'b0; end
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.busy_o || bus.done_o) cnt++;
    end
    chk("flush+start refused", 32'(cnt), 32'd0);
    chk("flush+start result", bus.result_o, 32'd4);

    // asynchronous reset mid-divide
    bus.op_i = MD_OP_DIVU; bus.rs1_val_i = 32'd100; bus.rs2_val_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre-reset busy", 32'(bus.busy_o), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async reset busy", 32'(bus.busy_o), 32'd0);
    chk("async reset done", 32'(bus.done_o), 32'd0);
    chk("async reset result", bus.result_o, 32'd0);
    chk("async reset state", 32'(bus.state), 32'(MD_ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post-reset mul", MD_OP_MUL, 32'd3, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
